// File: rtl/key_reg_loader.sv
// Serial key loader: shifts in a KEY_WIDTH-bit key MSB-first plus an even-parity bit,
// and commits it to the keyIn bus only when the parity checks clean.
module key_reg_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_start,
  input  logic                 i_key_bit,
  input  logic                 i_key_bit_valid,
  output logic                 o_key_bit_ready,
  output logic [KEY_WIDTH-1:0] o_key_out,
  output logic                 o_key_valid,
  output logic                 o_load_busy,
  output logic                 o_load_err,
  output logic [CNT_W-1:0]     o_bit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(KEY_WIDTH);

  state_t               r_state;
  logic [KEY_WIDTH-1:0] r_shadow;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_parity;
  logic                 r_key_valid;
  logic                 r_busy;
  logic                 r_err;
  logic [CNT_W-1:0]     r_count;

  state_t               w_state_nxt;
  logic [KEY_WIDTH-1:0] w_shadow_nxt;
  logic [KEY_WIDTH-1:0] w_key_nxt;
  logic                 w_parity_nxt;
  logic                 w_key_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_err_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_accept;
  logic                 w_parity_ok;

  assign w_accept    = (r_state == SHIFT) && i_key_bit_valid;
  assign w_parity_ok = ~((^r_shadow) ^ r_parity);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_key       <= '0;
      r_parity    <= 1'b0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_key       <= w_key_nxt;
      r_parity    <= w_parity_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_count     <= w_count_nxt;
    end
  end

  // load_start wins over everything, including a bit offered in the same cycle,
  // so an abort always restarts from a clean shadow and a zero count.
  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_key_nxt       = r_key;
    w_parity_nxt    = r_parity;
    w_key_valid_nxt = r_key_valid;
    w_busy_nxt      = r_busy;
    w_err_nxt       = r_err;
    w_count_nxt     = r_count;

    if (i_load_start) begin
      w_state_nxt  = SHIFT;
      w_shadow_nxt = '0;
      w_parity_nxt = 1'b0;
      w_count_nxt  = '0;
      w_err_nxt    = 1'b0;
      w_busy_nxt   = 1'b1;
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_accept) begin
            if (r_count < DATA_BITS) begin
              w_shadow_nxt = {r_shadow[KEY_WIDTH-2:0], i_key_bit};
            end else begin
              w_parity_nxt = i_key_bit;
              w_state_nxt  = CHECK;
            end
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        CHECK: begin
          if (w_parity_ok) begin
            w_key_nxt       = r_shadow;
            w_key_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign o_key_bit_ready = (r_state == SHIFT);
  assign o_key_out       = r_key;
  assign o_key_valid     = r_key_valid;
  assign o_load_busy     = r_busy;
  assign o_load_err      = r_err;
  assign o_bit_count     = r_count;

endmodule

// File: tb/tb_key_reg_loader.sv
// Self-checking bench for key_reg_loader: directed scenarios plus randomized transfers
// checked against a queue-based model of the key transfer protocol.
module tb_key_reg_loader;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        key_bit;
  logic        key_bit_valid;
  logic        key_bit_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        load_busy;
  logic        load_err;
  logic [5:0]  bit_count;

  int tests;
  int fails;

  // Model state: accepted bits of the current transfer, in arrival order.
  bit          mQ[$];
  bit          mBusy;
  bit          mPend;
  logic [31:0] mKey;
  bit          mValid;
  bit          mErr;

  key_reg_loader #(.KEY_WIDTH(32), .CNT_W(6)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load_start    (load_start),
    .i_key_bit       (key_bit),
    .i_key_bit_valid (key_bit_valid),
    .o_key_bit_ready (key_bit_ready),
    .o_key_out       (key_out),
    .o_key_valid     (key_valid),
    .o_load_busy     (load_busy),
    .o_load_err      (load_err),
    .o_bit_count     (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mQ.delete();
    mBusy  = 0;
    mPend  = 0;
    mKey   = '0;
    mValid = 0;
    mErr   = 0;
  endtask

  // Applies one cycle of inputs, advances the model by the protocol rules,
  // then returns 1 time unit after the edge with inputs idled.
  task automatic step(input bit ls, input bit v, input bit b);
    logic [31:0] k;
    load_start    = ls;
    key_bit_valid = v;
    key_bit       = b;
    if (ls) begin
      mQ.delete();
      mBusy = 1;
      mPend = 0;
      mErr  = 0;
    end else if (mPend) begin
      k = '0;
      for (int i = 0; i < 32; i++) k = {k[30:0], mQ[i]};
      if (($countones(k) + int'(mQ[32])) % 2 == 0) begin
        mKey   = k;
        mValid = 1;
      end else begin
        mErr = 1;
      end
      mBusy = 0;
      mPend = 0;
    end else if (mBusy && v) begin
      mQ.push_back(b);
      if (mQ.size() == 33) mPend = 1;
    end
    @(posedge clk);
    #1;
    load_start    = 0;
    key_bit_valid = 0;
    key_bit       = 0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit par);
    for (int i = 31; i >= 0; i--) step(0, 1, w[i]);
    step(0, 1, par);
  endtask

  task automatic test_reset();
    rst = 1;
    load_start = 0;
    key_bit = 0;
    key_bit_valid = 0;
    modelReset();
    #12;
    tests++;
    if (key_out !== 32'h0 || key_valid !== 1'b0 || load_busy !== 1'b0 ||
        load_err !== 1'b0 || bit_count !== 6'd0 || key_bit_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: key=%h valid=%b busy=%b err=%b cnt=%0d rdy=%b, want all zero",
               key_out, key_valid, load_busy, load_err, bit_count, key_bit_ready);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_load();
    step(1, 0, 0);
    tests++;
    if (key_bit_ready !== 1'b1 || load_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_start: rdy=%b busy=%b, want 1 1", key_bit_ready, load_busy);
    end
    sendWord(32'hA5A50F0F, 1'b0);
    tests++;
    if (key_valid !== 1'b0 || key_out !== 32'h0 || bit_count !== 6'd33) begin
      fails++;
      $display("[TB] FAIL basic_cycle33: valid=%b key=%h cnt=%0d, want 0 00000000 33",
               key_valid, key_out, bit_count);
    end
    step(0, 0, 0);
    tests++;
    if (key_out !== 32'hA5A50F0F || key_valid !== 1'b1 || load_err !== 1'b0 || load_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_commit: key=%h valid=%b err=%b busy=%b, want a5a50f0f 1 0 0",
               key_out, key_valid, load_err, load_busy);
    end
  endtask

  task automatic test_bad_parity();
    step(1, 0, 0);
    sendWord(32'h00000001, 1'b0);
    step(0, 0, 0);
    tests++;
    if (load_err !== 1'b1 || key_out !== 32'hA5A50F0F || key_valid !== 1'b1 || load_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bad_parity: err=%b key=%h valid=%b busy=%b, want 1 a5a50f0f 1 0",
               load_err, key_out, key_valid, load_busy);
    end
    step(0, 0, 0);
    tests++;
    if (load_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_sticky: err=%b, want 1", load_err);
    end
  endtask

  task automatic test_toggle_valid();
    logic [32:0] stream;
    stream = {32'hFFFFFFFF, 1'b0};
    step(1, 0, 0);
    tests++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_clear: err=%b, want 0", load_err);
    end
    for (int i = 32; i >= 0; i--) begin
      step(0, 1, stream[i]);
      if (i == 16) begin
        tests++;
        if (bit_count !== 6'd17 || bit_count !== 6'(mQ.size())) begin
          fails++;
          $display("[TB] FAIL toggle_count: cnt=%0d, want 17", bit_count);
        end
      end
      step(0, 0, 1'b1);
    end
    tests++;
    if (key_out !== 32'hFFFFFFFF || key_valid !== 1'b1 || load_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL toggle_commit: key=%h valid=%b err=%b, want ffffffff 1 0",
               key_out, key_valid, load_err);
    end
  endtask

  task automatic test_abort();
    bit stable;
    stable = 1;
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1'($urandom));
      if (key_out !== 32'hFFFFFFFF) stable = 0;
    end
    step(1, 0, 0);
    tests++;
    if (bit_count !== 6'd0 || key_bit_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_restart: cnt=%0d rdy=%b, want 0 1", bit_count, key_bit_ready);
    end
    for (int i = 31; i >= 0; i--) begin
      step(0, 1, 1'((32'h12345678 >> i) & 32'h1));
      if (key_out !== 32'hFFFFFFFF) stable = 0;
    end
    step(0, 1, 1'b1);
    if (key_out !== 32'hFFFFFFFF) stable = 0;
    tests++;
    if (!stable) begin
      fails++;
      $display("[TB] FAIL abort_stable: key changed mid-transfer, now %h, want ffffffff", key_out);
    end
    step(0, 0, 0);
    tests++;
    if (key_out !== 32'h12345678 || key_out !== mKey || key_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_commit: key=%h valid=%b, want 12345678 1", key_out, key_valid);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom));
    rst = 1;
    #1;
    tests++;
    if (key_out !== 32'h0 || key_valid !== 1'b0 || load_busy !== 1'b0 ||
        load_err !== 1'b0 || bit_count !== 6'd0 || key_bit_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: key=%h valid=%b busy=%b err=%b cnt=%0d rdy=%b, want all zero",
               key_out, key_valid, load_busy, load_err, bit_count, key_bit_ready);
    end
    modelReset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_collision();
    step(0, 1, 1);
    tests++;
    if (bit_count !== 6'd0 || load_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_ignore: cnt=%0d busy=%b, want 0 0", bit_count, load_busy);
    end
    step(1, 1, 1);
    tests++;
    if (bit_count !== 6'd0) begin
      fails++;
      $display("[TB] FAIL idle_start_bit: cnt=%0d, want 0", bit_count);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    step(1, 1, 1);
    tests++;
    if (bit_count !== 6'd0 || key_bit_ready !== 1'b1 || load_busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL collision: cnt=%0d rdy=%b busy=%b, want 0 1 1",
               bit_count, key_bit_ready, load_busy);
    end
  endtask

  task automatic test_random();
    int  steps;
    bit  ls;
    bit  v;
    for (int t = 0; t < 8; t++) begin
      step(1, 0, 0);
      steps = 0;
      while (mBusy && steps < 300) begin
        ls = ($urandom_range(0, 59) == 0);
        v  = ($urandom_range(0, 3) != 0);
        step(ls, v, 1'($urandom));
        steps++;
        tests++;
        if (key_out !== mKey || key_valid !== mValid || load_err !== mErr ||
            load_busy !== mBusy || bit_count !== 6'(mQ.size()) ||
            key_bit_ready !== (mBusy && !mPend)) begin
          fails++;
          $display("[TB] FAIL random_t%0d_s%0d: got key=%h v=%b e=%b b=%b c=%0d r=%b want key=%h v=%b e=%b b=%b c=%0d r=%b",
                   t, steps, key_out, key_valid, load_err, load_busy, bit_count, key_bit_ready,
                   mKey, mValid, mErr, mBusy, mQ.size(), (mBusy && !mPend));
        end
      end
      tests++;
      if (mBusy) begin
        fails++;
        $display("[TB] FAIL random_timeout_t%0d: transfer still busy=%b after %0d cycles, want 0",
                 t, load_busy, steps);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_load();
    test_bad_parity();
    test_toggle_valid();
    test_abort();
    test_reset_mid();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
